// File: rtl/alu_seq_pkg.sv
// Shared definitions for the LEGv8 ALU sequencer: op codes, ALU FS encodings,
// controller states and flag bit positions.
package alu_seq_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_ORR = 4'd1;
  localparam logic [3:0] OP_EOR = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_LSL = 4'd5;
  localparam logic [3:0] OP_LSR = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // Only the arithmetic ops and AND copy the ALU status into the flag register.
  function automatic logic op_takes_alu_flags(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake between datapath control and the ALU sequencer.
interface alu_seq_if #(
  parameter int DATA_W = 64
);
  logic              start;
  logic              in_ready;
  logic [3:0]        op;
  logic              set_flags;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic              result_valid;
  logic              result_ready;
  logic [DATA_W-1:0] result;
  logic              err;

  modport master (
    output start, op, set_flags, a_in, b_in, result_ready,
    input  in_ready, result_valid, result, err
  );

  modport slave (
    input  start, op, set_flags, a_in, b_in, result_ready,
    output in_ready, result_valid, result, err
  );
endinterface

// File: rtl/alu_seq_fs_decode.sv
// Combinational op -> ALU control decode. With ALU_SEQ_MUL_EN undefined,
// op 7 decodes as illegal.
module alu_seq_fs_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] op_i,
  output logic [4:0] fs_o,
  output logic       c0_o,
  output logic       legal_o,
  output logic       is_mul_o
);

  // Op code to FS/C0 and legality.
  always_comb begin
    fs_o     = 5'b00000;
    c0_o     = 1'b0;
    legal_o  = 1'b1;
    is_mul_o = 1'b0;
    case (op_i)
      OP_AND: fs_o = FS_AND;
      OP_ORR: fs_o = FS_ORR;
      OP_EOR: fs_o = FS_EOR;
      OP_ADD: fs_o = FS_ADD;
      OP_SUB: begin
        fs_o = FS_SUB;
        c0_o = 1'b1;
      end
      OP_LSL: fs_o = FS_LSL;
      OP_LSR: fs_o = FS_LSR;
      OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
        fs_o     = FS_ADD;
        is_mul_o = 1'b1;
`else
        legal_o  = 1'b0;
`endif
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Command-side sequencer for the external 64-bit LEGv8 ALU, keeps {V,C,N,Z}.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier (op 7).
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int         DATA_W    = 64,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic              clock,
  input  logic              reset,
  alu_seq_if.slave          bus,
  output logic [3:0]        flags,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [4:0]        alu_FS,
  output logic              alu_C0,
  input  logic [DATA_W-1:0] alu_F,
  input  logic [3:0]        alu_status
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]        op_q, op_d;
  logic              sf_q, sf_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              err_q, err_d;
  logic [3:0]        flags_q, flags_d;
`ifdef ALU_SEQ_MUL_EN
  logic [DATA_W-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
`endif

  logic [3:0] dec_op_s;
  logic [4:0] dec_fs_s;
  logic       dec_c0_s, dec_legal_s, dec_is_mul_s;

  // In IDLE the incoming op is classified; afterwards the registered op drives the ALU.
  assign dec_op_s = (state_q == ST_IDLE) ? bus.op : op_q;

  alu_seq_fs_decode u_decode (
    .op_i     (dec_op_s),
    .fs_o     (dec_fs_s),
    .c0_o     (dec_c0_s),
    .legal_o  (dec_legal_s),
    .is_mul_o (dec_is_mul_s)
  );

  assign bus.result = result_q;
  assign bus.err    = err_q;
  assign flags      = flags_q;

  // Next-state, datapath update and ALU drive.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    sf_d     = sf_q;
    result_d = result_q;
    err_d    = err_q;
    flags_d  = flags_q;
`ifdef ALU_SEQ_MUL_EN
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`endif
    alu_A            = {DATA_W{1'b0}};
    alu_B            = {DATA_W{1'b0}};
    alu_FS           = 5'b00000;
    alu_C0           = 1'b0;
    bus.in_ready     = 1'b0;
    bus.result_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.start) begin
          a_d   = bus.a_in;
          b_d   = bus.b_in;
          op_d  = bus.op;
          sf_d  = bus.set_flags;
          err_d = 1'b0;
          if (!dec_legal_s) begin
            state_d  = ST_DONE;
            result_d = {DATA_W{1'b0}};
            err_d    = 1'b1;
          end else if (dec_is_mul_s) begin
`ifdef ALU_SEQ_MUL_EN
            state_d  = ST_MUL;
            acc_d    = {DATA_W{1'b0}};
            mcand_d  = bus.a_in;
            mplier_d = bus.b_in;
`else
            state_d  = ST_DONE;
            result_d = {DATA_W{1'b0}};
            err_d    = 1'b1;
`endif
          end else begin
            state_d = ST_EXEC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        alu_A    = a_q;
        alu_B    = b_q;
        alu_FS   = dec_fs_s;
        alu_C0   = dec_c0_s;
        result_d = alu_F;
        state_d  = ST_DONE;
        if (sf_q && op_takes_alu_flags(op_q)) begin
          flags_d = alu_status;
        end else begin
          flags_d = flags_q;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: begin
        alu_A  = acc_q;
        alu_B  = mcand_q;
        alu_FS = dec_fs_s;
        alu_C0 = dec_c0_s;
        if (mplier_q[0]) begin
          acc_d = alu_F;
        end else begin
          acc_d = acc_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        // Exit test uses the shifted multiplier, so b=0 still runs one pass.
        if (mplier_d == {DATA_W{1'b0}}) begin
          state_d  = ST_DONE;
          result_d = acc_d;
          if (sf_q) begin
            flags_d         = 4'b0000;
            flags_d[FLAG_N] = acc_d[DATA_W-1];
            flags_d[FLAG_Z] = (acc_d == {DATA_W{1'b0}});
          end else begin
            flags_d = flags_q;
          end
        end else begin
          state_d = ST_MUL;
        end
      end
`endif
      ST_DONE: begin
        bus.result_valid = 1'b1;
        if (bus.result_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= {DATA_W{1'b0}};
      b_q      <= {DATA_W{1'b0}};
      op_q     <= 4'd0;
      sf_q     <= 1'b0;
      result_q <= {DATA_W{1'b0}};
      err_q    <= 1'b0;
      flags_q  <= FLAGS_RST;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= {DATA_W{1'b0}};
      mcand_q  <= {DATA_W{1'b0}};
      mplier_q <= {DATA_W{1'b0}};
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      sf_q     <= sf_d;
      result_q <= result_d;
      err_q    <= err_d;
      flags_q  <= flags_d;
`ifdef ALU_SEQ_MUL_EN
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural LEGv8 ALU.
module tb_alu_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  flags;
  logic [63:0] alu_A, alu_B, alu_F;
  logic [4:0]  alu_FS;
  logic        alu_C0;
  logic [3:0]  alu_status;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  alu_seq_if #(.DATA_W(64)) bus ();

  alu_sequencer #(.DATA_W(64), .FLAGS_RST(4'b0000)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.slave),
    .flags      (flags),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_FS     (alu_FS),
    .alu_C0     (alu_C0),
    .alu_F      (alu_F),
    .alu_status (alu_status)
  );

  always #5 clock = ~clock;

  // Reference ALU: FS[0] inverts B for the adder; status is {V,C,N,Z}.
  logic [64:0] sum_s;
  logic [63:0] bop_s;
  logic        v_s, c_s;
  always_comb begin
    bop_s = alu_FS[0] ? ~alu_B : alu_B;
    sum_s = {1'b0, alu_A} + {1'b0, bop_s} + {64'd0, alu_C0};
    v_s   = 1'b0;
    c_s   = 1'b0;
    case (alu_FS)
      5'b00000: alu_F = alu_A & alu_B;
      5'b00100: alu_F = alu_A | alu_B;
      5'b01100: alu_F = alu_A ^ alu_B;
      5'b01000, 5'b01001: begin
        alu_F = sum_s[63:0];
        c_s   = sum_s[64];
        v_s   = (alu_A[63] == bop_s[63]) && (sum_s[63] != alu_A[63]);
      end
      5'b10000: alu_F = alu_A << alu_B[5:0];
      5'b10100: alu_F = alu_A >> alu_B[5:0];
      default:  alu_F = 64'd0;
    endcase
    alu_status = {v_s, c_s, alu_F[63], (alu_F == 64'd0)};
  end

  task automatic send(input logic [3:0] op, input logic sf, input logic [63:0] a, input logic [63:0] b);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.set_flags = sf;
    bus.a_in      = a;
    bus.b_in      = b;
    @(posedge clock); #1;
    bus.start     = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (bus.result_valid !== 1'b1 && n < 64) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  task automatic consume();
    bus.result_ready = 1'b1;
    @(posedge clock); #1;
    bus.result_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = 4'd0; bus.set_flags = 1'b0;
    bus.a_in = 64'd0; bus.b_in = 64'd0; bus.result_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); else pass_cnt++;
    total_cnt++; if (bus.result_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.result_valid); else pass_cnt++;
    total_cnt++; if (bus.result !== 64'd0 || bus.err !== 1'b0) $display("FAIL rst_result: got %h/%b want 0/0", bus.result, bus.err); else pass_cnt++;
    total_cnt++; if (flags !== 4'b0000) $display("FAIL rst_flags: got %b want 0000", flags); else pass_cnt++;
    total_cnt++; if (alu_A !== 64'd0 || alu_B !== 64'd0 || alu_FS !== 5'd0 || alu_C0 !== 1'b0)
      $display("FAIL rst_alu: got A=%h B=%h FS=%b C0=%b want zeros", alu_A, alu_B, alu_FS, alu_C0); else pass_cnt++;
  endtask

  task automatic test_add();
    int n;
    send(4'd3, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    total_cnt++; if (alu_FS !== 5'b01000 || alu_A !== 64'h7FFF_FFFF_FFFF_FFFF)
      $display("FAIL add_drive: got FS=%b A=%h want 01000/7fff..", alu_FS, alu_A); else pass_cnt++;
    wait_valid(n);
    total_cnt++; if (n !== 2) $display("FAIL add_latency: got %0d want 2", n); else pass_cnt++;
    total_cnt++; if (bus.result !== 64'h8000_0000_0000_0000) $display("FAIL add_result: got %h want 8000000000000000", bus.result); else pass_cnt++;
    total_cnt++; if (flags !== 4'b1010) $display("FAIL add_flags: got %b want 1010", flags); else pass_cnt++;
    consume();
  endtask

  task automatic test_sub();
    int n;
    send(4'd4, 1'b1, 64'd5, 64'd5);
    total_cnt++; if (alu_FS !== 5'b01001 || alu_C0 !== 1'b1) $display("FAIL sub_drive: got FS=%b C0=%b want 01001/1", alu_FS, alu_C0); else pass_cnt++;
    wait_valid(n);
    total_cnt++; if (n !== 2) $display("FAIL sub_latency: got %0d want 2", n); else pass_cnt++;
    total_cnt++; if (bus.result !== 64'd0 || bus.err !== 1'b0) $display("FAIL sub_result: got %h/%b want 0/0", bus.result, bus.err); else pass_cnt++;
    total_cnt++; if (flags !== 4'b0101) $display("FAIL sub_flags: got %b want 0101", flags); else pass_cnt++;
    consume();
  endtask

  task automatic test_lsl();
    int n;
    send(4'd5, 1'b1, 64'd1, 64'h43);
    wait_valid(n);
    total_cnt++; if (bus.result !== 64'd8) $display("FAIL lsl_result: got %h want 8", bus.result); else pass_cnt++;
    total_cnt++; if (flags !== 4'b0101) $display("FAIL lsl_flags: got %b want 0101", flags); else pass_cnt++;
    consume();
    send(4'd6, 1'b0, 64'hF000_0000_0000_0000, 64'd4);
    wait_valid(n);
    total_cnt++; if (bus.result !== 64'h0F00_0000_0000_0000) $display("FAIL lsr_result: got %h want 0f00000000000000", bus.result); else pass_cnt++;
    consume();
  endtask

  task automatic test_mul();
    int n;
`ifdef ALU_SEQ_MUL_EN
    send(4'd7, 1'b0, 64'h1234, 64'd10);
    total_cnt++; if (alu_FS !== 5'b01000 || alu_C0 !== 1'b0) $display("FAIL mul_drive: got FS=%b C0=%b want 01000/0", alu_FS, alu_C0); else pass_cnt++;
    wait_valid(n);
    total_cnt++; if (n !== 5) $display("FAIL mul_latency: got %0d want 5", n); else pass_cnt++;
    total_cnt++; if (bus.result !== 64'hB608 || bus.err !== 1'b0) $display("FAIL mul_result: got %h/%b want b608/0", bus.result, bus.err); else pass_cnt++;
    total_cnt++; if (flags !== 4'b0101) $display("FAIL mul_flags_hold: got %b want 0101", flags); else pass_cnt++;
    consume();
    send(4'd7, 1'b1, 64'h1234, 64'd0);
    wait_valid(n);
    total_cnt++; if (n !== 2) $display("FAIL mul0_latency: got %0d want 2", n); else pass_cnt++;
    total_cnt++; if (bus.result !== 64'd0) $display("FAIL mul0_result: got %h want 0", bus.result); else pass_cnt++;
    total_cnt++; if (flags !== 4'b0001) $display("FAIL mul0_flags: got %b want 0001", flags); else pass_cnt++;
    consume();
`else
    send(4'd7, 1'b1, 64'h1234, 64'd10);
    wait_valid(n);
    total_cnt++; if (n !== 1) $display("FAIL mul_off_latency: got %0d want 1", n); else pass_cnt++;
    total_cnt++; if (bus.err !== 1'b1 || bus.result !== 64'd0) $display("FAIL mul_off_err: got %b/%h want 1/0", bus.err, bus.result); else pass_cnt++;
    total_cnt++; if (flags !== 4'b0101) $display("FAIL mul_off_flags: got %b want 0101", flags); else pass_cnt++;
    consume();
`endif
  endtask

  task automatic test_back_to_back();
    int n;
    send(4'd0, 1'b1, 64'hF0, 64'h3C);
    wait_valid(n);
    total_cnt++; if (flags !== 4'b0000) $display("FAIL and_flags: got %b want 0000", flags); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'b1; bus.op = 4'd3; bus.a_in = 64'd99; bus.b_in = 64'd1;
      @(posedge clock); #1;
      total_cnt++;
      if (bus.result !== 64'h30 || bus.result_valid !== 1'b1 || bus.in_ready !== 1'b0)
        $display("FAIL hold_%0d: got res=%h v=%b rdy=%b want 30/1/0", i, bus.result, bus.result_valid, bus.in_ready);
      else pass_cnt++;
    end
    total_cnt++; if (alu_FS !== 5'd0 || alu_A !== 64'd0) $display("FAIL done_alu_idle: got FS=%b A=%h want 0/0", alu_FS, alu_A); else pass_cnt++;
    bus.start = 1'b0;
    consume();
    total_cnt++; if (bus.result_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL release: got v=%b rdy=%b want 0/1", bus.result_valid, bus.in_ready); else pass_cnt++;
    send(4'd3, 1'b0, 64'd2, 64'd3);
    wait_valid(n);
    total_cnt++; if (bus.result !== 64'd5 || n !== 2) $display("FAIL next_accept: got %h lat %0d want 5 lat 2", bus.result, n); else pass_cnt++;
    consume();
  endtask

  task automatic test_reset_mid();
    int n;
    send(4'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    wait_valid(n);
    total_cnt++; if (bus.result !== 64'd0 || flags !== 4'b0101) $display("FAIL carry_wrap: got %h/%b want 0/0101", bus.result, flags); else pass_cnt++;
    consume();
    send(4'd7, 1'b1, 64'd3, 64'hFF);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    total_cnt++; if (bus.in_ready !== 1'b1 || bus.result_valid !== 1'b0) $display("FAIL midrst_hs: got rdy=%b v=%b want 1/0", bus.in_ready, bus.result_valid); else pass_cnt++;
    total_cnt++; if (flags !== 4'b0000 || bus.result !== 64'd0 || alu_A !== 64'd0) $display("FAIL midrst_state: got f=%b r=%h A=%h want 0", flags, bus.result, alu_A); else pass_cnt++;
    send(4'd4, 1'b1, 64'd5, 64'd5);
    wait_valid(n);
    consume();
    send(4'hF, 1'b1, 64'd7, 64'd9);
    wait_valid(n);
    total_cnt++; if (n !== 1) $display("FAIL illegal_latency: got %0d want 1", n); else pass_cnt++;
    total_cnt++; if (bus.err !== 1'b1 || bus.result !== 64'd0) $display("FAIL illegal_err: got %b/%h want 1/0", bus.err, bus.result); else pass_cnt++;
    total_cnt++; if (flags !== 4'b0101) $display("FAIL illegal_flags: got %b want 0101", flags); else pass_cnt++;
    consume();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_lsl();
    test_mul();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion want finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-side initiator for the 64-bit LEGv8 ALU. Accepts one operation request at a time over a valid/ready handshake and decodes it into ALU FS/C0 controls. Drives the ALU's A/B inputs and captures F and status.
- Keeps the architectural flag register {V,C,N,Z} for the S-suffix instructions.
- Runs 64-bit MUL as a multi-cycle shift-add loop through the ALU adder.
- Sits between the datapath control and the combinational ALU; the ALU is instantiated outside this block.

Parameters:
- DATA_W, 64, operand/result width; must match the ALU.
- FLAGS_RST, 4'b0000, reset value of the flag register.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- op  in  4  operation code (see package).
- set_flags  in  1  update flags on completion.
- a_in  in  DATA_W  operand A.
- b_in  in  DATA_W  operand B; only [5:0] is significant for shifts.
- result_valid  out  1  result/err valid; held until consumed.
- result_ready  in  1  consumer accepts the result.
- result  out  DATA_W  operation result.
- err  out  1  illegal op; qualified by result_valid.
- flags  out  4  {V,C,N,Z} flag register.
- alu_A  out  DATA_W  to ALU A.
- alu_B  out  DATA_W  to ALU B.
- alu_FS  out  5  to ALU FS.
- alu_C0  out  1  to ALU C0.
- alu_F  in  DATA_W  ALU result.
- alu_status  in  4  ALU {V,C,N,Z}.

Behaviour:
- Reset: state IDLE; in_ready=1; result_valid=0; result=0; err=0; flags=FLAGS_RST; alu_* = 0.
- Handshake:
  - Accept when start & in_ready. a_in, b_in, op and set_flags are registered on accept.
  - start is ignored whenever in_ready=0.
  - The output transfers when result_valid & result_ready.
- Op codes and ALU drive:
  - AND=0: FS 00000, C0=0.
  - ORR=1: FS 00100, C0=0.
  - EOR=2: FS 01100, C0=0.
  - ADD=3: FS 01000, C0=0.
  - SUB=4: FS 01001, C0=1.
  - LSL=5: FS 10000, C0=0.
  - LSR=6: FS 10100, C0=0.
  - MUL=7: iterative, uses ADD controls.
  - 8-15 illegal.
- States:
  - IDLE -> EXEC (single-cycle op), MUL (op 7) or DONE (illegal; result=0, err=1).
  - EXEC: drive the ALU from the registered operands for one cycle, capture alu_F at the cycle end, go to DONE.
  - MUL: each cycle drives alu_A=acc and alu_B=mcand with ADD controls. If mplier[0]=1 then acc<=alu_F; mcand<<=1; mplier>>=1.
  - MUL exit: leave to DONE when the shifted mplier==0, with a minimum of 1 iteration. The result is the low DATA_W bits of acc.
  - DONE: result_valid=1; result and err held stable. On result_ready go to IDLE, and result_valid drops the same edge.
- Latency (accept edge = cycle 0):
  - Single-cycle ops: result_valid at cycle 2.
  - MUL: result_valid at cycle 1+k, where k = index of the highest set bit of b + 1 (k=1 for b=0).
  - Illegal ops: result_valid at cycle 1.
- Flags:
  - Updated at entry to DONE, only if set_flags=1.
  - ADD/SUB/AND: flags <= alu_status.
  - MUL: N=result[63], Z=(result==0), C=V=0.
  - ORR/EOR/LSL/LSR and illegal ops: flags unchanged.
- alu_* outputs hold 0 outside EXEC/MUL.
- Reset mid-operation: abort the operation, return to IDLE next cycle, restore all reset values, and discard any pending result.
- Flag wrap: adder carry-out appears in C; 64-bit overflow appears in V (ALU status, unmodified).

Optional Feature:
- ALU_SEQ_MUL_EN.
- Defined: MUL state and iterative multiply present as above.
- Undefined: no MUL state or mcand/mplier/acc registers; op 7 is treated as illegal (err=1, result=0, result_valid at cycle 1).

Decomposition:
- Package alu_seq_pkg holds:
  - op code localparams;
  - FS constants per op;
  - state encoding (IDLE, EXEC, MUL, DONE);
  - flag bit indices V=3, C=2, N=1, Z=0.
- One sub-module, alu_seq_fs_decode: combinational op -> {FS, C0, legal, is_mul}.

Test Plan:
1. ADD, set_flags=1, a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> result 0x8000_0000_0000_0000 and flags 4'b1010, with result_valid 2 cycles after accept.
2. SUB, set_flags=1, a=5, b=5 -> alu_FS=01001 and alu_C0=1 during EXEC; result 0; flags 4'b0101.
3. LSL, set_flags=1, a=1, b=0x43 -> result 8; flags unchanged from the previous value.
4. MUL, a=0x1234, b=10 -> result 0xB608, result_valid at cycle 5. MUL with b=0, set_flags=1 -> result 0 at cycle 2, flags 4'b0001. With ALU_SEQ_MUL_EN undefined -> err=1.
5. Backpressure: hold result_ready=0 for 5 cycles -> result stable, in_ready=0, start ignored; raise result_ready -> IDLE next cycle, and the next start is accepted.
6. Reset asserted mid-MUL -> next cycle in_ready=1, result_valid=0, flags=FLAGS_RST. Op 0xF -> err=1, result 0, flags unchanged.
